// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the 4-bit pseudo-random count sequence
// 1,3,5,0,2,4,6,7,8,9,A,F,E,D,C,B (then back to 1).
// Contents:
//   seq_state_e : checker FSM encoding (IDLE=0, SEARCH=1, LOCKED=2, 3 unused)
//   SEQ_START   : first value of the sequence, also the reset value of prev
//   succ()      : successor of any 4-bit value along the sequence
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEARCH    = 2'd1,
      LOCKED    = 2'd2,
      ST_UNUSED = 2'd3
   } seq_state_e;

   localparam logic [3:0] SEQ_START = 4'h1;

   // Every 4-bit value appears exactly once in the cycle, so the table is
   // total and B wraps back to the start value.
   function automatic logic [3:0] succ(input logic [3:0] x);
      logic [3:0] r;
      r = SEQ_START;
      case (x)
         4'h1: r = 4'h3;
         4'h3: r = 4'h5;
         4'h5: r = 4'h0;
         4'h0: r = 4'h2;
         4'h2: r = 4'h4;
         4'h4: r = 4'h6;
         4'h6: r = 4'h7;
         4'h7: r = 4'h8;
         4'h8: r = 4'h9;
         4'h9: r = 4'hA;
         4'hA: r = 4'hF;
         4'hF: r = 4'hE;
         4'hE: r = 4'hD;
         4'hD: r = 4'hC;
         4'hC: r = 4'hB;
         4'hB: r = 4'h1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_next.sv
// seq_next: combinational successor lookup for the count sequence.
// Ports:
//   cur : current sequence value
//   nxt : value that must follow cur
module seq_next
   import seq_pkg::*;
(
   input  logic [3:0] cur,
   output logic [3:0] nxt
);

   assign nxt = succ(cur);

endmodule

// File: rtl/seq_checker.sv
// seq_checker: online monitor for the pseudo-random count sequence. It locks
// after LOCK_N consecutive correct successors and then reports every break
// with a one-cycle err pulse and a saturating break counter.
// Parameters:
//   LOCK_N : consecutive correct transitions needed to lock (1..15)
//   ERR_W  : width of err_cnt
// Ports:
//   clk      : clock, all updates on the rising edge
//   rst      : asynchronous active-low reset
//   en       : din valid this cycle; when low all state holds
//   din      : sampled counter value
//   locked   : high while locked onto the sequence
//   err      : one-cycle pulse on a break detected while locked
//   err_cnt  : number of breaks seen while locked, saturating
//   expected : successor of the last sample (SEQ_START when idle)
//   state    : FSM state for debug
module seq_checker
   import seq_pkg::*;
#(
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       din,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       expected,
   output logic [1:0]       state
);

   localparam int RUN_W = $clog2(LOCK_N + 1);
   localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(LOCK_N);
   localparam logic [ERR_W-1:0] CNT_MAX    = '1;

   seq_state_e       state_q, state_d;
   logic [3:0]       prev_q, prev_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   logic [3:0]       succ_prev;
   logic [RUN_W-1:0] run_inc;
   logic             hit;

   // One successor lookup serves both the judgement and the expected output.
   seq_next u_next (
      .cur (prev_q),
      .nxt (succ_prev)
   );

   assign hit     = (din == succ_prev);
   assign run_inc = run_q + RUN_W'(1);

   // Next-state logic. err defaults low so it can only ever be a single-cycle
   // pulse. Every enabled sample becomes the new prev, so after a break the
   // checker re-synchronises on the offending value.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      run_d   = run_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (state_q == ST_UNUSED) begin
         state_d = IDLE;
         run_d   = '0;
         if (en) prev_d = din;
      end else if (en) begin
         prev_d = din;
         case (state_q)
            IDLE: begin
               run_d   = '0;
               state_d = SEARCH;
            end
            SEARCH: begin
               if (hit) begin
                  if (run_inc == RUN_TARGET) begin
                     state_d = LOCKED;
                     run_d   = '0;
                  end else begin
                     run_d = run_inc;
                  end
               end else begin
                  run_d = '0;
               end
            end
            LOCKED: begin
               if (!hit) begin
                  err_d   = 1'b1;
                  run_d   = '0;
                  state_d = SEARCH;
                  if (cnt_q != CNT_MAX) cnt_d = cnt_q + ERR_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; reset clears everything, including an err pulse in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         prev_q  <= SEQ_START;
         run_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         run_q   <= run_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign locked   = (state_q == LOCKED);
   assign err      = err_q;
   assign err_cnt  = cnt_q;
   assign expected = (state_q == SEARCH || state_q == LOCKED) ? succ_prev : SEQ_START;
   assign state    = state_q;

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: self-checking bench for seq_checker. A main instance uses the
// default parameters; a second instance (LOCK_N=1, ERR_W=2) covers counter
// saturation. Expected values come from a sequence-list reference model.
module tb_seq_checker;

   localparam int LOCK_N = 4;
   localparam int ERR_W  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [3:0] din = 4'h0;
   logic       locked, err;
   logic [7:0] err_cnt;
   logic [3:0] expected;
   logic [1:0] state;

   logic       s_en  = 1'b0;
   logic [3:0] s_din = 4'h0;
   logic       s_locked, s_err;
   logic [1:0] s_err_cnt;
   logic [3:0] s_expected;
   logic [1:0] s_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_checker #(.LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din),
      .locked(locked), .err(err), .err_cnt(err_cnt),
      .expected(expected), .state(state)
   );

   seq_checker #(.LOCK_N(1), .ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(s_en), .din(s_din),
      .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt),
      .expected(s_expected), .state(s_state)
   );

   // Reference model: the sequence as a list; successor = next list entry.
   logic [3:0] order [16] = '{4'h1, 4'h3, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6, 4'h7,
                              4'h8, 4'h9, 4'hA, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB};
   bit         m_started, m_locked, m_err;
   int         m_run, m_cnt;
   logic [3:0] m_prev;

   function automatic logic [3:0] ref_succ(input logic [3:0] x);
      logic [3:0] r;
      r = 4'h1;
      for (int i = 0; i < 16; i++)
         if (order[i] == x) r = order[(i + 1) % 16];
      return r;
   endfunction

   function automatic logic [1:0] m_state();
      return !m_started ? 2'd0 : (m_locked ? 2'd2 : 2'd1);
   endfunction

   function automatic logic [3:0] m_expected();
      return m_started ? ref_succ(m_prev) : 4'h1;
   endfunction

   task automatic model_reset();
      m_started = 0; m_locked = 0; m_err = 0; m_run = 0; m_cnt = 0; m_prev = 4'h1;
   endtask

   // Drive one sample on the falling edge (as the producer does), advance the
   // model at the rising edge, and return 1 time unit later for sampling.
   task automatic step(input logic e, input logic [3:0] d);
      @(negedge clk);
      en = e; din = d;
      @(posedge clk);
      m_err = 0;
      if (e) begin
         if (!m_started) begin
            m_started = 1; m_run = 0;
         end else if (d == ref_succ(m_prev)) begin
            if (!m_locked) begin
               m_run++;
               if (m_run == LOCK_N) begin m_locked = 1; m_run = 0; end
            end
         end else begin
            if (m_locked) begin
               m_err = 1; m_locked = 0;
               if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
            end
            m_run = 0;
         end
         m_prev = d;
      end
      #1;
   endtask

   task automatic sat_step(input logic e, input logic [3:0] d);
      @(negedge clk);
      s_en = e; s_din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         en = 1'($urandom); din = 4'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({state, locked, err, err_cnt, expected} !== {2'd0, 1'b0, 1'b0, 8'd0, 4'h1}) begin
            errors++;
            $display("[TB] FAIL reset_hold: got st=%0d lk=%0b err=%0b cnt=%0d exp=%h, want 0 0 0 0 1",
                     state, locked, err, err_cnt, expected);
         end
      end
      @(negedge clk);
      en = 1'b0; rst = 1'b1;
   endtask

   task automatic test_lock();
      step(1'b1, 4'h1);
      checks++;
      if (state !== 2'd1 || locked !== 1'b0) begin
         errors++; $display("[TB] FAIL lock_search: got st=%0d lk=%0b, want 1 0", state, locked);
      end
      foreach (order[i]) if (i >= 1 && i <= 3) begin
         step(1'b1, order[i]);
         checks++;
         if (locked !== 1'b0) begin
            errors++; $display("[TB] FAIL lock_early: got lk=%0b, want 0 at din=%h", locked, order[i]);
         end
      end
      step(1'b1, 4'h2);
      checks++;
      if (locked !== 1'b1 || expected !== 4'h4 || state !== 2'd2) begin
         errors++;
         $display("[TB] FAIL lock_enter: got lk=%0b exp=%h st=%0d, want 1 4 2", locked, expected, state);
      end
   endtask

   task automatic test_break();
      step(1'b1, 4'h7);
      checks++;
      if ({err, err_cnt, locked, state, expected} !== {1'b1, 8'd1, 1'b0, 2'd1, 4'h8}) begin
         errors++;
         $display("[TB] FAIL break: got err=%0b cnt=%0d lk=%0b st=%0d exp=%h, want 1 1 0 1 8",
                  err, err_cnt, locked, state, expected);
      end
      step(1'b1, 4'h8);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("[TB] FAIL break_pulse: got err=%0b, want 0", err);
      end
      step(1'b1, 4'h9);
      step(1'b1, 4'hA);
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("[TB] FAIL relock_early: got lk=%0b, want 0", locked);
      end
      step(1'b1, 4'hF);
      checks++;
      if (locked !== 1'b1 || err_cnt !== 8'd1 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL relock: got lk=%0b cnt=%0d err=%0b, want 1 1 0", locked, err_cnt, err);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] vals [6] = '{4'hE, 4'hD, 4'hC, 4'hB, 4'h1, 4'h3};
      foreach (vals[i]) begin
         step(1'b1, vals[i]);
         checks++;
         if (err !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap: din=%h got err=%0b lk=%0b, want 0 1", vals[i], err, locked);
         end
      end
   endtask

   task automatic test_enable_gaps();
      int         cnt0;
      logic [3:0] exp0;
      cnt0 = m_cnt;
      exp0 = ref_succ(m_prev);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'($urandom));
         checks++;
         if ({state, err, err_cnt, expected} !== {2'd2, 1'b0, 8'(cnt0), exp0}) begin
            errors++;
            $display("[TB] FAIL gap_hold: got st=%0d err=%0b cnt=%0d exp=%h, want 2 0 %0d %h",
                     state, err, err_cnt, expected, cnt0, exp0);
         end
      end
      step(1'b1, exp0);
      checks++;
      if (err !== 1'b0 || locked !== 1'b1 || err_cnt !== 8'(cnt0)) begin
         errors++;
         $display("[TB] FAIL gap_resume: got err=%0b lk=%0b cnt=%0d, want 0 1 %0d", err, locked, err_cnt, cnt0);
      end
   endtask

   task automatic test_random();
      logic       e;
      logic [3:0] d;
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 9) < 8);
         d = ($urandom_range(0, 7) != 0) ? ref_succ(m_prev) : 4'($urandom);
         step(e, d);
         checks++;
         if ({state, locked, err, err_cnt, expected} !==
             {m_state(), m_locked, m_err, 8'(m_cnt), m_expected()}) begin
            errors++;
            $display("[TB] FAIL random[%0d]: got st=%0d lk=%0b err=%0b cnt=%0d exp=%h, want %0d %0b %0b %0d %h",
                     i, state, locked, err, err_cnt, expected,
                     m_state(), m_locked, m_err, m_cnt, m_expected());
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i <= LOCK_N; i++) step(1'b1, ref_succ(m_prev));
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("[TB] FAIL async_pre: got lk=%0b, want 1", locked);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({state, locked, err, err_cnt, expected} !== {2'd0, 1'b0, 1'b0, 8'd0, 4'h1}) begin
         errors++;
         $display("[TB] FAIL async_locked: got st=%0d lk=%0b err=%0b cnt=%0d exp=%h, want 0 0 0 0 1",
                  state, locked, err, err_cnt, expected);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i <= LOCK_N; i++) step(1'b1, ref_succ(m_prev));
      step(1'b1, m_prev);
      checks++;
      if (err !== 1'b1 || err_cnt !== 8'd1) begin
         errors++; $display("[TB] FAIL repeat_break: got err=%0b cnt=%0d, want 1 1", err, err_cnt);
      end
      #1 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({state, locked, err, err_cnt, expected} !== {2'd0, 1'b0, 1'b0, 8'd0, 4'h1}) begin
         errors++;
         $display("[TB] FAIL async_err: got st=%0d lk=%0b err=%0b cnt=%0d exp=%h, want 0 0 0 0 1",
                  state, locked, err, err_cnt, expected);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_saturation();
      logic [3:0] sp;
      int         pulses;
      int         want;
      pulses = 0;
      sat_step(1'b1, 4'h1);
      sp = 4'h1;
      checks++;
      if (s_state !== 2'd1) begin
         errors++; $display("[TB] FAIL sat_start: got st=%0d, want 1", s_state);
      end
      for (int i = 1; i <= 5; i++) begin
         sp = ref_succ(sp);
         sat_step(1'b1, sp);
         checks++;
         if (s_locked !== 1'b1 || s_err !== 1'b0) begin
            errors++; $display("[TB] FAIL sat_lock[%0d]: got lk=%0b err=%0b, want 1 0", i, s_locked, s_err);
         end
         sat_step(1'b1, sp);
         if (s_err === 1'b1) pulses++;
         want = (i < 3) ? i : 3;
         checks++;
         if (s_err !== 1'b1 || s_locked !== 1'b0 || s_err_cnt !== 2'(want)) begin
            errors++;
            $display("[TB] FAIL sat_break[%0d]: got err=%0b lk=%0b cnt=%0d, want 1 0 %0d",
                     i, s_err, s_locked, s_err_cnt, want);
         end
      end
      sat_step(1'b0, 4'h0);
      checks++;
      if (pulses != 5 || s_err !== 1'b0 || s_err_cnt !== 2'd3) begin
         errors++;
         $display("[TB] FAIL sat_total: got pulses=%0d err=%0b cnt=%0d, want 5 0 3", pulses, s_err, s_err_cnt);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock();
      test_break();
      test_wrap();
      test_enable_gaps();
      test_random();
      test_async_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
